escritura_rafaga: RTL and testbench

Write sequencer that pairs with the register read controller: it writes a burst of consecutive registers on the peripheral bus, starting at a given address. For each register it requests a data word from the upstream source, presents the address and data to the bus driver, and holds them until the driver pulses completion. It sits between the control FSM (iniciar/final handshake) and the low-level bus driver (activa/fin handshake).

---
 rtl/escritura_rafaga_if.sv | 29 ++
 rtl/escritura_rafaga.sv | 118 +++++++++++
 tb/tb_escritura_rafaga.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/escritura_rafaga_if.sv
// Handshake and bus signals between the control FSM, the upstream data source,
// the bus driver and the escritura_rafaga write sequencer.
interface escritura_rafaga_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          iniciar;
  logic [AW-1:0] dir;
  logic [7:0]    largo;
  logic [DW-1:0] dato;
  logic          dato_ok;
  logic          fin;
  logic [AW-1:0] dir_out;
  logic [DW-1:0] dato_out;
  logic          pide_dato;
  logic          activa;
  // Burst-complete flag; 'final' itself is a reserved word in SystemVerilog.
  logic          finalizado;

  modport master (
    output iniciar, dir, largo, dato, dato_ok, fin,
    input  dir_out, dato_out, pide_dato, activa, finalizado
  );

  modport slave (
    input  iniciar, dir, largo, dato, dato_ok, fin,
    output dir_out, dato_out, pide_dato, activa, finalizado
  );
endinterface

// File: rtl/escritura_rafaga.sv
// Burst write sequencer: fetches one word per register from the upstream source
// and hands (address, data) to the bus driver until the burst length is exhausted.
module escritura_rafaga #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  escritura_rafaga_if.slave  bus
);

  typedef enum logic [1:0] {
    INICIO    = 2'd0,
    PIDE      = 2'd1,
    ESCRIBE   = 2'd2,
    FINALIZAR = 2'd3
  } estado_t;

  estado_t       estado, estado_sig;
  logic [AW-1:0] dir_reg, dir_reg_sig;
  logic [7:0]    cuenta, cuenta_sig;
  logic [AW-1:0] dir_out_q, dir_out_sig;
  logic [DW-1:0] dato_out_q, dato_out_sig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado     <= INICIO;
      dir_reg    <= '0;
      cuenta     <= '0;
      dir_out_q  <= '0;
      dato_out_q <= '0;
    end else begin
      estado     <= estado_sig;
      dir_reg    <= dir_reg_sig;
      cuenta     <= cuenta_sig;
      dir_out_q  <= dir_out_sig;
      dato_out_q <= dato_out_sig;
    end
  end

  // Output registers are cleared on every transition into INICIO/FINALIZAR so
  // that the idle and done states never expose a stale address or data word.
  always_comb begin
    estado_sig   = estado;
    dir_reg_sig  = dir_reg;
    cuenta_sig   = cuenta;
    dir_out_sig  = dir_out_q;
    dato_out_sig = dato_out_q;

    case (estado)
      INICIO: begin
        dir_out_sig  = '0;
        dato_out_sig = '0;
        if (bus.iniciar) begin
          if (bus.largo != 8'd0) begin
            dir_reg_sig = bus.dir;
            cuenta_sig  = bus.largo;
            estado_sig  = PIDE;
          end else begin
            estado_sig  = FINALIZAR;
          end
        end
      end

      PIDE: begin
        if (!bus.iniciar) begin
          dir_out_sig  = '0;
          dato_out_sig = '0;
          estado_sig   = INICIO;
        end else if (bus.dato_ok) begin
          dir_out_sig  = dir_reg;
          dato_out_sig = bus.dato;
          estado_sig   = ESCRIBE;
        end
      end

      // A started bus write always runs to fin; abort is only honoured afterwards.
      ESCRIBE: begin
        if (bus.fin) begin
          if (!bus.iniciar) begin
            dir_out_sig  = '0;
            dato_out_sig = '0;
            estado_sig   = INICIO;
          end else if (cuenta == 8'd1) begin
            dir_out_sig  = '0;
            dato_out_sig = '0;
            estado_sig   = FINALIZAR;
          end else begin
            dir_reg_sig  = dir_reg + 1'b1;
            cuenta_sig   = cuenta - 8'd1;
            estado_sig   = PIDE;
          end
        end
      end

      FINALIZAR: begin
        dir_out_sig  = '0;
        dato_out_sig = '0;
        if (!bus.iniciar) begin
          estado_sig = INICIO;
        end
      end

      default: begin
        dir_out_sig  = '0;
        dato_out_sig = '0;
        estado_sig   = INICIO;
      end
    endcase
  end

  assign bus.pide_dato  = (estado == PIDE);
  assign bus.activa     = (estado == ESCRIBE);
  assign bus.finalizado = (estado == FINALIZAR);
  assign bus.dir_out    = dir_out_q;
  assign bus.dato_out   = dato_out_q;

endmodule

// File: tb/tb_escritura_rafaga.sv
// Self-checking bench for escritura_rafaga: randomized bursts checked against a
// word-list reference (address = start + index mod 256, data = supplied word).
module tb_escritura_rafaga;

  logic clk = 1'b0;
  logic reset;

  escritura_rafaga_if #(.DW(8), .AW(8)) bus ();

  escritura_rafaga #(.DW(8), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  datos [256];

  function automatic logic [18:0] outs();
    return {bus.pide_dato, bus.activa, bus.finalizado, bus.dir_out, bus.dato_out};
  endfunction

  task automatic idle_inputs();
    bus.iniciar = 1'b0;
    bus.dir     = 8'h00;
    bus.largo   = 8'h00;
    bus.dato    = 8'h00;
    bus.dato_ok = 1'b0;
    bus.fin     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 19'd0)
      $display("FAIL reset_state: got %h expected 0", outs());
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 19'd0)
      $display("FAIL after_reset_idle: got %h expected 0", outs());
  endtask

  task automatic test_reset_mid_escribe();
    bus.iniciar = 1'b1;
    bus.dir     = 8'h40;
    bus.largo   = 8'd5;
    bus.dato    = 8'h5A;
    bus.dato_ok = 1'b1;
    for (int i = 0; i < 10 && !bus.activa; i++) @(negedge clk);
    checks++;
    if (!bus.activa || bus.dir_out !== 8'h40 || bus.dato_out !== 8'h5A) begin
      errors++;
      $display("FAIL rst_mid_write_setup: activa=%b dir_out=%h dato_out=%h expected 1/40/5a",
               bus.activa, bus.dir_out, bus.dato_out);
    end
    #2;
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    bus.dato_ok = 1'b0;
    #1;
    checks++;
    if (outs() !== 19'd0) begin
      errors++;
      $display("FAIL rst_async_clear: got %h expected 0", outs());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 19'd0) begin
      errors++;
      $display("FAIL rst_held: got %h expected 0", outs());
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 19'd0) begin
        errors++;
        $display("FAIL rst_release_idle: cycle %0d got %h expected 0", i, outs());
      end
    end
  endtask

  // Drives one full burst; 'tied' holds dato_ok/fin high, otherwise random 0..lat_max waits.
  task automatic run_burst(input logic [7:0] d0, input logic [7:0] len,
                           input int unsigned lat_max, input bit tied);
    int unsigned nw = 0, n = 0, wsrc, wfin;
    int unsigned budget;
    bit          prev_act = 1'b0, seen_req = 1'b0, done = 1'b0;
    logic [7:0]  ha = '0, hd = '0, ea;
    budget = 16 * int'(len) + 16;
    wsrc = $urandom_range(lat_max, 0);
    wfin = $urandom_range(lat_max, 0);
    bus.dir     = d0;
    bus.largo   = len;
    bus.dato    = datos[0];
    bus.dato_ok = tied;
    bus.fin     = tied;
    bus.iniciar = 1'b1;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.pide_dato || bus.activa) seen_req = 1'b1;
      if (bus.activa && !prev_act) begin
        ea = d0 + nw[7:0];
        checks++;
        if (bus.dir_out !== ea || bus.dato_out !== datos[nw]) begin
          errors++;
          $display("FAIL write_word%0d: got (%h,%h) expected (%h,%h)",
                   nw, bus.dir_out, bus.dato_out, ea, datos[nw]);
        end
        ha = bus.dir_out;
        hd = bus.dato_out;
        nw++;
      end else if (bus.activa) begin
        checks++;
        if (bus.dir_out !== ha || bus.dato_out !== hd) begin
          errors++;
          $display("FAIL write_stable: got (%h,%h) expected (%h,%h)",
                   bus.dir_out, bus.dato_out, ha, hd);
        end
      end
      prev_act = bus.activa;
      if (bus.finalizado) begin
        done = 1'b1;
      end else begin
        bus.dato = datos[nw];
        if (!tied) begin
          if (bus.pide_dato) begin
            if (wsrc == 0) begin
              bus.dato_ok = 1'b1;
              wsrc = $urandom_range(lat_max, 0);
            end else begin
              bus.dato_ok = 1'b0;
              wsrc--;
            end
          end else begin
            bus.dato_ok = 1'($urandom_range(1, 0));
          end
          if (bus.activa) begin
            if (wfin == 0) begin
              bus.fin = 1'b1;
              wfin = $urandom_range(lat_max, 0);
            end else begin
              bus.fin = 1'b0;
              wfin--;
            end
          end else begin
            bus.fin = 1'($urandom_range(1, 0));
          end
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL burst_timeout: final=%b after %0d cycles expected 1", bus.finalizado, n);
    end
    checks++;
    if (nw != int'(len)) begin
      errors++;
      $display("FAIL burst_word_count: got %0d expected %0d", nw, len);
    end
    if (tied) begin
      checks++;
      if (n != 2 * int'(len) + 1) begin
        errors++;
        $display("FAIL burst_latency: final after %0d edges expected %0d", n - 1, 2 * int'(len));
      end
    end
    if (len == 8'd0) begin
      checks++;
      if (seen_req) begin
        errors++;
        $display("FAIL len0_no_request: got request=1 expected 0");
      end
    end
    checks++;
    if (bus.dir_out !== 8'h00 || bus.dato_out !== 8'h00 || bus.pide_dato || bus.activa) begin
      errors++;
      $display("FAIL final_outputs: got %h expected 3 bits 001 and zero bus", outs());
    end
    bus.dato_ok = 1'b0;
    bus.fin     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.finalizado !== 1'b1 || bus.pide_dato !== 1'b0) begin
        errors++;
        $display("FAIL final_hold: final=%b pide=%b expected 1/0", bus.finalizado, bus.pide_dato);
      end
    end
    bus.iniciar = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 19'd0) begin
      errors++;
      $display("FAIL final_release: got %h expected 0", outs());
    end
    if (!done) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_tied();
    datos[0] = 8'hA1;
    datos[1] = 8'hA2;
    datos[2] = 8'hA3;
    run_burst(8'h10, 8'd3, 0, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) datos[i] = 8'($urandom_range(255, 0));
    run_burst(8'hFE, 8'd3, 5, 1'b0);
  endtask

  task automatic test_largo_cero();
    run_burst(8'($urandom_range(255, 0)), 8'd0, 2, 1'b0);
  endtask

  task automatic test_random_bursts();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 256; i++) datos[i] = 8'($urandom_range(255, 0));
      run_burst(8'($urandom_range(255, 0)), 8'($urandom_range(8, 1)), 3, b == 4);
    end
  endtask

  task automatic test_abort_pide(input bit con_dato);
    bus.dato_ok = 1'b0;
    bus.fin     = 1'b0;
    bus.dir     = 8'($urandom_range(255, 0));
    bus.largo   = 8'd4;
    bus.iniciar = 1'b1;
    for (int i = 0; i < 4 && !bus.pide_dato; i++) @(negedge clk);
    checks++;
    if (bus.pide_dato !== 1'b1) begin
      errors++;
      $display("FAIL abort_pide_setup: pide=%b expected 1", bus.pide_dato);
    end
    bus.fin = 1'b1;
    @(negedge clk);
    bus.fin = 1'b0;
    checks++;
    if (bus.pide_dato !== 1'b1 || bus.activa !== 1'b0) begin
      errors++;
      $display("FAIL stray_fin_pide: pide=%b activa=%b expected 1/0", bus.pide_dato, bus.activa);
    end
    bus.iniciar = 1'b0;
    bus.dato_ok = con_dato;
    bus.dato    = 8'($urandom_range(255, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.dato_ok = 1'b0;
      checks++;
      if (outs() !== 19'd0) begin
        errors++;
        $display("FAIL abort_pide(dato_ok=%0b): cycle %0d got %h expected 0", con_dato, i, outs());
      end
    end
  endtask

  task automatic test_abort_escribe();
    bus.dato_ok = 1'b0;
    bus.fin     = 1'b0;
    bus.dir     = 8'h77;
    bus.largo   = 8'd3;
    bus.dato    = 8'h3C;
    bus.iniciar = 1'b1;
    for (int i = 0; i < 4 && !bus.pide_dato; i++) @(negedge clk);
    bus.dato_ok = 1'b1;
    @(negedge clk);
    bus.dato_ok = 1'b0;
    checks++;
    if (bus.activa !== 1'b1 || bus.dir_out !== 8'h77 || bus.dato_out !== 8'h3C) begin
      errors++;
      $display("FAIL abort_wr_setup: activa=%b dir=%h dato=%h expected 1/77/3c",
               bus.activa, bus.dir_out, bus.dato_out);
    end
    bus.iniciar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.activa !== 1'b1 || bus.finalizado !== 1'b0 ||
          bus.dir_out !== 8'h77 || bus.dato_out !== 8'h3C) begin
        errors++;
        $display("FAIL abort_wr_holds: activa=%b final=%b dir=%h dato=%h expected 1/0/77/3c",
                 bus.activa, bus.finalizado, bus.dir_out, bus.dato_out);
      end
    end
    bus.fin = 1'b1;
    @(negedge clk);
    bus.fin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs() !== 19'd0) begin
        errors++;
        $display("FAIL abort_wr_idle: cycle %0d got %h expected 0", i, outs());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle_stray();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      bus.dato_ok = 1'($urandom_range(1, 0));
      bus.fin     = 1'($urandom_range(1, 0));
      bus.dir     = 8'($urandom_range(255, 0));
      bus.largo   = 8'($urandom_range(255, 0));
      @(negedge clk);
      checks++;
      if (outs() !== 19'd0) begin
        errors++;
        $display("FAIL idle_stray: cycle %0d got %h expected 0", i, outs());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid_escribe();
    test_tied();
    test_wrap();
    test_largo_cero();
    test_random_bursts();
    test_abort_pide(1'b0);
    test_abort_pide(1'b1);
    test_abort_escribe();
    test_idle_stray();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
